// File: rtl/alu_issue_if.sv
// alu_issue_if: valid/ready decode-in and ALU-out bundle for alu_issue.
interface alu_issue_if #(parameter int DATAWIDTH = 32, parameter int CNTWIDTH = 32);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [DATAWIDTH-1:0] in_pc;
   logic [DATAWIDTH-1:0] in_rs1_data;
   logic [DATAWIDTH-1:0] in_rs2_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_op;
   logic [DATAWIDTH-1:0] out_rs1;
   logic [DATAWIDTH-1:0] out_rs2;
   logic [4:0]           out_rd;
   logic                 out_illegal;
   logic [CNTWIDTH-1:0]  issue_count;
   modport master (output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
                   input in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_illegal, issue_count);
   modport slave  (input in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
                   output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_illegal, issue_count);
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I/M ALU-class decoder feeding the ALU through a 2-entry skid buffer.
module alu_issue #(
   parameter int DATAWIDTH = 32,
   parameter int CNTWIDTH  = 32
) (
   input logic       clk,
   input logic       RSTn,
   alu_issue_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   typedef struct packed {
      logic [3:0]           op;
      logic [DATAWIDTH-1:0] rs1;
      logic [DATAWIDTH-1:0] rs2;
      logic [4:0]           rd;
      logic                 ill;
   } ent_t;

   state_t              r_state, w_next;
   ent_t                w_dec, r_out, r_skid;
   logic [CNTWIDTH-1:0] r_cnt;
   logic [31:0]         w_i;
   logic [6:0]          w_f7;
   logic [2:0]          w_f3;
   logic [3:0]          w_f3op;
   logic                w_shift, w_acc, w_drn;

   assign w_i     = bus.in_instr;
   assign w_f7    = w_i[31:25];
   assign w_f3    = w_i[14:12];
   assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

   always_comb begin
      w_f3op = 4'd4;
      case (w_f3)
         3'b001:  w_f3op = 4'd1;
         3'b010:  w_f3op = 4'd7;
         3'b011:  w_f3op = 4'd8;
         3'b100:  w_f3op = 4'd9;
         3'b101:  w_f3op = 4'd2;
         3'b110:  w_f3op = 4'd10;
         3'b111:  w_f3op = 4'd11;
         default: w_f3op = 4'd4;
      endcase
   end

   // Illegal encodings still issue as ADD 0,0 so the pipeline sees every instruction
   always_comb begin
      w_dec     = '0;
      w_dec.op  = 4'd4;
      w_dec.rd  = w_i[11:7];
      case (w_i[6:0])
         7'b0110011:
            if (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                (w_f7 == 7'b0000001 && w_f3 == 3'b000)) begin
               w_dec.op  = (w_f7 == 7'b0000001) ? 4'd12 :
                           (w_f7 == 7'b0100000) ? ((w_f3 == 3'b000) ? 4'd5 : 4'd3) : w_f3op;
               w_dec.rs1 = bus.in_rs1_data;
               w_dec.rs2 = bus.in_rs2_data;
            end else
               w_dec.ill = 1'b1;
         7'b0010011:
            if (!w_shift || w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && w_f3 == 3'b101)) begin
               w_dec.op  = (w_f3 == 3'b101 && w_f7[5]) ? 4'd3 : w_f3op;
               w_dec.rs1 = bus.in_rs1_data;
               w_dec.rs2 = w_shift ? {27'd0, w_i[24:20]} : {{20{w_i[31]}}, w_i[31:20]};
            end else
               w_dec.ill = 1'b1;
         7'b0110111: begin
            w_dec.op  = 4'd6;
            w_dec.rs2 = {w_i[31:12], 12'h000};
         end
         7'b0010111: begin
            w_dec.rs1 = bus.in_pc;
            w_dec.rs2 = {w_i[31:12], 12'h000};
         end
         default: w_dec.ill = 1'b1;
      endcase
   end

   assign w_acc = bus.in_valid && (r_state != FULL);
   assign w_drn = (r_state != EMPTY) && bus.out_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY:   w_next = w_acc ? ONE : EMPTY;
         ONE:     w_next = (w_acc && !w_drn) ? FULL : (w_drn && !w_acc) ? EMPTY : ONE;
         FULL:    w_next = w_drn ? ONE : FULL;
         default: w_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= EMPTY;
         r_out   <= '0;
         r_skid  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc && (r_state == EMPTY || w_drn)) r_out <= w_dec;
         else if (r_state == FULL && w_drn) r_out <= r_skid;
         if (w_acc && r_state == ONE && !w_drn) r_skid <= w_dec;
         if (w_drn) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready    = (r_state != FULL);
   assign bus.out_valid   = (r_state != EMPTY);
   assign bus.out_op      = r_out.op;
   assign bus.out_rs1     = r_out.rs1;
   assign bus.out_rs2     = r_out.rs2;
   assign bus.out_rd      = r_out.rd;
   assign bus.out_illegal = r_out.ill;
   assign bus.issue_count = r_cnt;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue decode, skid ordering, counter wrap and reset.
module tb_alu_issue;
   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic       clk = 1'b0;
   logic       RSTn = 1'b0;
   int         total = 0;
   int         bad = 0;
   exp_t       sb[$];
   logic [3:0] exp_cnt = 4'd0;
   logic       prev_stall = 1'b0;
   exp_t       held;

   alu_issue_if #(.DATAWIDTH(32), .CNTWIDTH(4)) bus ();
   alu_issue #(.DATAWIDTH(32), .CNTWIDTH(4)) dut (.clk(clk), .RSTn(RSTn), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic ill);
      mk = '{op: op, rs1: a, rs2: b, rd: rd, ill: ill};
   endfunction

   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc = pc;
      bus.in_rs1_data = a;
      bus.in_rs2_data = b;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk("accept_timeout", n, 0);
      else sb.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         n++;
         @(posedge clk);
      end
      chk("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!RSTn) prev_stall <= 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_op", bus.out_op, held.op);
            chk("hold_rs1", bus.out_rs1, held.rs1);
            chk("hold_rs2", bus.out_rs2, held.rs2);
            chk("hold_rd", bus.out_rd, held.rd);
         end
         prev_stall <= bus.out_valid && !bus.out_ready;
         held <= mk(bus.out_op, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_illegal);
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("op", bus.out_op, e.op);
               chk("rs1", bus.out_rs1, e.rs1);
               chk("rs2", bus.out_rs2, e.rs2);
               chk("rd", bus.out_rd, e.rd);
               chk("illegal", bus.out_illegal, e.ill);
            end
            chk("count", bus.issue_count, exp_cnt);
            exp_cnt = exp_cnt + 4'd1;
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.in_pc = '0;
      bus.in_rs1_data = '0;
      bus.in_rs2_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_op", bus.out_op, 0);
      chk("rst_count", bus.issue_count, 0);
      RSTn = 1'b1;
      @(posedge clk);
      #1;
      send(32'h002081B3, 0, 5, 7, mk(4'd4, 5, 7, 5'd3, 0));
      send(32'h402081B3, 0, 9, 2, mk(4'd5, 9, 2, 5'd3, 0));
      send(32'h40435293, 0, 32'h80000000, 1, mk(4'd3, 32'h80000000, 4, 5'd5, 0));
      send(32'h123450B7, 0, 3, 3, mk(4'd6, 0, 32'h12345000, 5'd1, 0));
      send(32'hFFF00093, 0, 11, 0, mk(4'd4, 11, 32'hFFFFFFFF, 5'd1, 0));
      send(32'h022081B3, 0, 6, 8, mk(4'd12, 6, 8, 5'd3, 0));
      send(32'h0020B1B3, 0, 1, 2, mk(4'd8, 1, 2, 5'd3, 0));
      send(32'h00001297, 32'h400, 1, 2, mk(4'd4, 32'h400, 32'h1000, 5'd5, 0));
      send(32'h042081B3, 0, 1, 2, mk(4'd4, 0, 0, 5'd3, 1));
      send(32'h40409093, 0, 1, 2, mk(4'd4, 0, 0, 5'd1, 1));
      send(32'hFFFFFFFF, 0, 1, 2, mk(4'd4, 0, 0, 5'd31, 1));
      wait_drain();
      bus.out_ready = 1'b0;
      fork
         begin
            send(32'h002081B3, 0, 1, 1, mk(4'd4, 1, 1, 5'd3, 0));
            send(32'h402081B3, 0, 2, 1, mk(4'd5, 2, 1, 5'd3, 0));
            send(32'h0020B1B3, 0, 3, 1, mk(4'd8, 3, 1, 5'd3, 0));
         end
         begin
            repeat (2) @(posedge clk);
            #2 chk("full_in_ready", bus.in_ready, 0);
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("burst_count", bus.issue_count, exp_cnt);
      bus.out_ready = 1'b0;
      send(32'h002081B3, 0, 4, 4, mk(4'd4, 4, 4, 5'd3, 0));
      send(32'h002081B3, 0, 5, 5, mk(4'd4, 5, 5, 5'd3, 0));
      #3 RSTn = 1'b0;
      #1;
      chk("rst_full_valid", bus.out_valid, 0);
      chk("rst_full_count", bus.issue_count, 0);
      sb.delete();
      exp_cnt = 4'd0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 RSTn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_valid", bus.out_valid, 0);
      chk("post_rst_ready", bus.in_ready, 1);
      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         send(32'h002081B3, 0, a, b, mk(4'd4, a, b, 5'd3, 0));
      end
      wait_drain();
      chk("wrap_count", bus.issue_count, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
